// File: rtl/mux_route_sched.sv
// mux_route_sched: shares the routing mux CTRL select among NREQ requesters.
// Each grant latches a mode and a window length, then blanks downstream for PIPE_LAT
// cycles when the mode changes and opens a data window of the latched length.
// Build option: define MUX_SCHED_RR_EN for round-robin arbitration; without it the
// lowest-index requester wins and no pointer register exists.
module mux_route_sched #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned CW       = 3,
    parameter int unsigned LW       = 8,
    parameter int unsigned PIPE_LAT = 2,
    parameter int unsigned DEF_MODE = 0
) (
    input  logic                 SYS_CLK,
    input  logic                 SYS_RST_N,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*CW-1:0]   mode_i,
    input  logic [NREQ*LW-1:0]   len_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [CW-1:0]        CTRL,
    output logic [NREQ-1:0]      owner_o,
    output logic                 blank_o,
    output logic                 win_o,
    output logic                 done_o,
    output logic                 busy_o
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // Switch counter holds PIPE_LAT-1 down to 0.
    localparam int unsigned SW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [1:0] {StIdle, StSwitch, StHold} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   ctrl_q, ctrl_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] owner_q, owner_d;
    logic [LW-1:0]   len_q, len_d;
    logic [SW-1:0]   sw_q, sw_d;

    logic [CW-1:0]   mode_arr [NREQ];
    logic [LW-1:0]   len_arr  [NREQ];
    logic [NREQ-1:0] cand;
    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic            done;
    logic            arb;

    for (genvar g = 0; g < int'(NREQ); g++) begin : g_unpack
        assign mode_arr[g] = mode_i[g*CW +: CW];
        assign len_arr[g]  = len_i[g*LW +: LW];
    end

`ifdef MUX_SCHED_RR_EN
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] rr_idx;

    // Round-robin pick: first candidate at or after the pointer, wrapping.
    always_comb begin
        cand      = req_i & ~gnt_q;
        win_found = 1'b0;
        win_idx   = '0;
        rr_idx    = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            rr_idx = IW'((int'(ptr_q) + i) % int'(NREQ));
            if (!win_found && cand[rr_idx]) begin
                win_found = 1'b1;
                win_idx   = rr_idx;
            end
        end
    end

    // Pointer moves past the winner only when a grant is issued.
    always_comb begin
        ptr_d = ptr_q;
        if (arb && win_found) begin
            ptr_d = (int'(win_idx) == int'(NREQ) - 1) ? '0 : win_idx + IW'(1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority: scanning downward leaves the lowest requesting index.
    always_comb begin
        cand      = req_i & ~gnt_q;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_found = 1'b1;
                win_idx   = IW'(i);
            end
        end
    end
`endif

    // Next-state: sequence SWITCH/HOLD counters and take a new winner at arbitration points.
    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        gnt_d   = '0;
        owner_d = owner_q;
        len_d   = len_q;
        sw_d    = sw_q;
        done    = (state_q == StHold) && (len_q == LW'(1));
        arb     = (state_q == StIdle) || done;

        unique case (state_q)
            StSwitch: begin
                if (sw_q == '0) begin
                    state_d = StHold;
                end else begin
                    sw_d = sw_q - SW'(1);
                end
            end
            StHold: begin
                len_d = len_q - LW'(1);
                if (done) begin
                    state_d = StIdle;
                    owner_d = '0;
                end
            end
            default: ;
        endcase

        if (arb && win_found) begin
            gnt_d   = NREQ'(1) << win_idx;
            owner_d = NREQ'(1) << win_idx;
            ctrl_d  = mode_arr[win_idx];
            len_d   = (len_arr[win_idx] == '0) ? LW'(1) : len_arr[win_idx];
            sw_d    = SW'(PIPE_LAT - 1);
            // Same mode needs no blanking: the mux pipeline already carries that mode.
            state_d = (mode_arr[win_idx] != ctrl_q) ? StSwitch : StHold;
        end
    end

    // State and output registers.
    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            state_q <= StIdle;
            ctrl_q  <= CW'(DEF_MODE);
            gnt_q   <= '0;
            owner_q <= '0;
            len_q   <= '0;
            sw_q    <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            len_q   <= len_d;
            sw_q    <= sw_d;
        end
    end

    assign gnt_o   = gnt_q;
    assign CTRL    = ctrl_q;
    assign owner_o = owner_q;
    assign blank_o = (state_q == StSwitch);
    assign win_o   = (state_q == StHold);
    assign done_o  = done;
    assign busy_o  = (state_q != StIdle);

endmodule
